// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the inter-layer activation buffers: default sample
// width, bank count, bank-occupancy encoding and width helpers.
package cnn_buf_pkg;

   localparam int unsigned BIT_WIDTH_DEF = 32'd16;
   localparam int unsigned NUM_BANKS     = 32'd2;

   typedef enum logic [1:0] {
      FULL_EMPTY = 2'd0,
      FULL_ONE   = 2'd1,
      FULL_TWO   = 2'd2
   } full_cnt_e;

   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned result;
      result = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 32'd1;
      end
      return (result == 32'd0) ? 32'd1 : result;
   endfunction

   function automatic full_cnt_e full_cnt_inc(input full_cnt_e cnt);
      full_cnt_e res;
      case (cnt)
         FULL_EMPTY: res = FULL_ONE;
         FULL_ONE:   res = FULL_TWO;
         default:    res = FULL_TWO;
      endcase
      return res;
   endfunction

   function automatic full_cnt_e full_cnt_dec(input full_cnt_e cnt);
      full_cnt_e res;
      case (cnt)
         FULL_TWO: res = FULL_ONE;
         FULL_ONE: res = FULL_EMPTY;
         default:  res = FULL_EMPTY;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/conv1d_window_buffer_if.sv
// Producer/consumer bus of the ping-pong window buffer. The master side is the
// layer pair driving writes and window reads, the slave side is the buffer.
interface conv1d_window_buffer_if
   import cnn_buf_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
   parameter int unsigned CHANNELS  = 32'd8,
   parameter int unsigned LENGTH    = 32'd256,
   parameter int unsigned KERNEL    = 32'd3
);
   localparam int unsigned CH_W  = clog2_min1(CHANNELS);
   localparam int unsigned POS_W = clog2_min1(LENGTH);

   logic                          wr_en;
   logic [CH_W-1:0]               wr_ch;
   logic [POS_W-1:0]              wr_pos;
   logic signed [BIT_WIDTH-1:0]   wr_data;
   logic                          wr_last;
   logic                          wr_ready;
   logic                          wr_err;

   logic                          rd_en;
   logic [CH_W-1:0]               rd_ch;
   logic [POS_W-1:0]              rd_pos;
   logic                          rd_done;
   logic                          rd_avail;
   logic                          rd_valid;
   logic [KERNEL*BIT_WIDTH-1:0]   rd_taps;

   modport master (
      output wr_en, wr_ch, wr_pos, wr_data, wr_last,
      output rd_en, rd_ch, rd_pos, rd_done,
      input  wr_ready, wr_err, rd_avail, rd_valid, rd_taps
   );

   modport slave (
      input  wr_en, wr_ch, wr_pos, wr_data, wr_last,
      input  rd_en, rd_ch, rd_pos, rd_done,
      output wr_ready, wr_err, rd_avail, rd_valid, rd_taps
   );

endinterface

// File: rtl/conv1d_bank_ctrl.sv
// Ping-pong bank ownership: write/read bank pointers, occupancy count and the
// commit/release handshake shared by all inter-layer buffers.
module conv1d_bank_ctrl
   import cnn_buf_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic wr_en_i,
   input  logic wr_last_i,
   input  logic wr_in_range_i,
   input  logic rd_done_i,
   output logic wr_accept_o,
   output logic wr_bank_o,
   output logic rd_bank_o,
   output logic wr_ready_o,
   output logic rd_avail_o,
   output logic wr_err_o
);

   full_cnt_e full_cnt_q, full_cnt_d;
   logic      wr_bank_q, wr_bank_d;
   logic      rd_bank_q, rd_bank_d;
   logic      wr_err_q, wr_err_d;
   logic      commit_s, release_s;

   assign wr_ready_o  = (full_cnt_q != FULL_TWO);
   assign rd_avail_o  = (full_cnt_q != FULL_EMPTY);
   assign wr_accept_o = wr_en_i && wr_ready_o && wr_in_range_i;
   assign wr_bank_o   = wr_bank_q;
   assign rd_bank_o   = rd_bank_q;
   assign wr_err_o    = wr_err_q;

   // Next bank state; a same-cycle commit and release cancel in the count.
   always_comb begin
      commit_s  = wr_accept_o && wr_last_i;
      release_s = rd_done_i && rd_avail_o;
      wr_err_d  = wr_en_i && !wr_ready_o;
      wr_bank_d = wr_bank_q ^ commit_s;
      rd_bank_d = rd_bank_q ^ release_s;
      case ({commit_s, release_s})
         2'b10:   full_cnt_d = full_cnt_inc(full_cnt_q);
         2'b01:   full_cnt_d = full_cnt_dec(full_cnt_q);
         default: full_cnt_d = full_cnt_q;
      endcase
   end

   // Bank state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_cnt_q <= FULL_EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         full_cnt_q <= full_cnt_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_err_q   <= wr_err_d;
      end
   end

endmodule

// File: rtl/conv1d_window_buffer.sv
// Double-buffered CONV1D activation store: one bank is filled by the producer
// while Kernel-tap zero-padded windows are read from the other.
module conv1d_window_buffer
   import cnn_buf_pkg::*;
#(
   parameter int unsigned Bit_width = BIT_WIDTH_DEF,
   parameter int unsigned Channels  = 32'd8,
   parameter int unsigned Length    = 32'd256,
   parameter int unsigned Kernel    = 32'd3
)(
   input logic                   clk,
   input logic                   rst_n,
   conv1d_window_buffer_if.slave bus
);

   localparam int unsigned POS_W = clog2_min1(Length);
   localparam int          HALF  = int'((Kernel - 32'd1) / 32'd2);

   logic [Bit_width-1:0]        mem_q [NUM_BANKS][Channels][Length];
   logic [Kernel*Bit_width-1:0] taps_d, taps_q;
   logic                        rd_valid_d, rd_valid_q;

   logic wr_in_range_s, wr_accept_s, wr_bank_s;
   logic rd_in_range_s, rd_accept_s, rd_bank_s, rd_avail_s;
   int   tap_pos_s;

   assign wr_in_range_s = (32'(bus.wr_ch) < Channels) && (32'(bus.wr_pos) < Length);
   assign rd_in_range_s = (32'(bus.rd_ch) < Channels) && (32'(bus.rd_pos) < Length);
   assign rd_accept_s   = bus.rd_en && rd_avail_s;

   conv1d_bank_ctrl u_bank_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en_i       (bus.wr_en),
      .wr_last_i     (bus.wr_last),
      .wr_in_range_i (wr_in_range_s),
      .rd_done_i     (bus.rd_done),
      .wr_accept_o   (wr_accept_s),
      .wr_bank_o     (wr_bank_s),
      .rd_bank_o     (rd_bank_s),
      .wr_ready_o    (bus.wr_ready),
      .rd_avail_o    (rd_avail_s),
      .wr_err_o      (bus.wr_err)
   );

   assign bus.rd_avail = rd_avail_s;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_taps  = taps_q;

   // Sample storage; contents deliberately carry no reset.
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_q[wr_bank_s][bus.wr_ch][bus.wr_pos] <= bus.wr_data;
      end
   end

   // Kernel parallel read muxes; taps falling outside the sequence read as zero.
   always_comb begin
      taps_d     = '0;
      tap_pos_s  = 0;
      rd_valid_d = rd_accept_s;
      for (int j = 0; j < int'(Kernel); j++) begin
         tap_pos_s = int'(bus.rd_pos) + j - HALF;
         if (rd_in_range_s && (tap_pos_s >= 0) && (tap_pos_s < int'(Length))) begin
            taps_d[j*Bit_width +: Bit_width] = mem_q[rd_bank_s][bus.rd_ch][tap_pos_s[POS_W-1:0]];
         end else begin
            taps_d[j*Bit_width +: Bit_width] = '0;
         end
      end
   end

   // Window output register; taps hold their value between accepted reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taps_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         if (rd_accept_s) begin
            taps_q <= taps_d;
         end else begin
            taps_q <= taps_q;
         end
      end
   end

endmodule

// File: tb/tb_conv1d_window_buffer.sv
// Scoreboard bench: Kernel=3 and Kernel=5 buffers share one stimulus stream and
// are checked against a frame-level reference model.
module tb_conv1d_window_buffer;
   import cnn_buf_pkg::*;

   localparam int BW = 16;
   localparam int C  = 6;
   localparam int L  = 200;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   conv1d_window_buffer_if #(.BIT_WIDTH(BW), .CHANNELS(C), .LENGTH(L), .KERNEL(3)) if3 ();
   conv1d_window_buffer_if #(.BIT_WIDTH(BW), .CHANNELS(C), .LENGTH(L), .KERNEL(5)) if5 ();

   assign if5.wr_en   = if3.wr_en;
   assign if5.wr_ch   = if3.wr_ch;
   assign if5.wr_pos  = if3.wr_pos;
   assign if5.wr_data = if3.wr_data;
   assign if5.wr_last = if3.wr_last;
   assign if5.rd_en   = if3.rd_en;
   assign if5.rd_ch   = if3.rd_ch;
   assign if5.rd_pos  = if3.rd_pos;
   assign if5.rd_done = if3.rd_done;

   conv1d_window_buffer #(.Bit_width(BW), .Channels(C), .Length(L), .Kernel(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(if3));
   conv1d_window_buffer #(.Bit_width(BW), .Channels(C), .Length(L), .Kernel(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .bus(if5));

   // Reference model: frame memory, committed-frame count and bank roles.
   logic [15:0] mem_m [2][C][L];
   int          cnt_m, wb_m, rb_m;
   logic [79:0] q3[$], q5[$];
   logic [79:0] last3, last5;
   bit          last_wr_ok;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [79:0] window(input int k, input int b, input int ch, input int pos);
      logic [79:0] w;
      int p;
      w = '0;
      for (int j = 0; j < k; j++) begin
         p = pos + j - (k - 1) / 2;
         if (ch < C && pos < L && p >= 0 && p < L) w[j*16 +: 16] = mem_m[b][ch][p];
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_wr_ready_k3", if3.wr_ready, 1'b1);
      chk("rst_rd_avail_k3", if3.rd_avail, 1'b0);
      chk("rst_rd_valid_k3", if3.rd_valid, 1'b0);
      chk("rst_rd_taps_k3",  {32'd0, if3.rd_taps}, 80'd0);
      chk("rst_wr_ready_k5", if5.wr_ready, 1'b1);
      chk("rst_rd_avail_k5", if5.rd_avail, 1'b0);
      chk("rst_rd_valid_k5", if5.rd_valid, 1'b0);
      chk("rst_rd_taps_k5",  {16'd0, if5.rd_taps}, 80'd0);
   endtask

   task automatic model_reset();
      cnt_m = 0; wb_m = 0; rb_m = 0;
      last3 = '0; last5 = '0;
      q3.delete(); q5.delete();
   endtask

   task automatic drive_idle();
      if3.wr_en = 1'b0; if3.wr_ch = '0; if3.wr_pos = '0; if3.wr_data = '0; if3.wr_last = 1'b0;
      if3.rd_en = 1'b0; if3.rd_ch = '0; if3.rd_pos = '0; if3.rd_done = 1'b0;
   endtask

   // One clock of stimulus; the model advances at the edge, flags are checked 1 time unit later.
   task automatic step(input bit we, input int wch, input int wpos, input logic [15:0] wd,
                       input bit wl, input bit re, input int rch, input int rpos, input bit done);
      int pre;
      bit acc;
      if3.wr_en = we; if3.wr_ch = 3'(wch); if3.wr_pos = 8'(wpos); if3.wr_data = wd;
      if3.wr_last = wl; if3.rd_en = re; if3.rd_ch = 3'(rch); if3.rd_pos = 8'(rpos);
      if3.rd_done = done;
      @(posedge clk);
      pre = cnt_m;
      if (re && pre > 0) begin
         last3 = window(3, rb_m, rch, rpos);
         last5 = window(5, rb_m, rch, rpos);
         q3.push_back(last3);
         q5.push_back(last5);
      end
      acc = we && pre < 2 && wch < C && wpos < L;
      last_wr_ok = acc;
      if (acc) mem_m[wb_m][wch][wpos] = wd;
      if (acc && wl) begin wb_m = 1 - wb_m; cnt_m++; end
      if (done && pre > 0) begin rb_m = 1 - rb_m; cnt_m--; end
      #1;
      chk("wr_err_k3",   if3.wr_err,   we && pre == 2);
      chk("wr_err_k5",   if5.wr_err,   we && pre == 2);
      chk("wr_ready_k3", if3.wr_ready, cnt_m < 2);
      chk("rd_avail_k3", if3.rd_avail, cnt_m > 0);
      chk("rd_avail_k5", if5.rd_avail, cnt_m > 0);
      if (re && pre == 0) begin
         chk("taps_hold_k3", {32'd0, if3.rd_taps}, last3);
         chk("taps_hold_k5", {16'd0, if5.rd_taps}, last5);
      end
   endtask

   task automatic rd(input int ch, input int pos);
      step(1'b0, 0, 0, 16'd0, 1'b0, 1'b1, ch, pos, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 0, 0, 16'd0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // mode 1: ch2 pos i = 100+i; mode 2: ch0 pos i = i+1; other samples random.
   task automatic fill_frame(input int mode, input bit with_oor, input bit done_on_last);
      logic [15:0] d;
      bit lst;
      for (int c = 0; c < C; c++) begin
         for (int i = 0; i < L; i++) begin
            lst = (c == C - 1) && (i == L - 1);
            if (mode == 1 && c == 2)      d = 16'(100 + i);
            else if (mode == 2 && c == 0) d = 16'(i + 1);
            else                          d = 16'($urandom);
            if (lst && with_oor) begin
               step(1'b1, 7, 10, 16'h1234, 1'b0, 1'b0, 0, 0, 1'b0);
               step(1'b1, 2, 210, 16'h5678, 1'b0, 1'b0, 0, 0, 1'b0);
            end
            step(1'b1, c, i, d, lst, 1'b0, 0, 0, lst && done_on_last);
         end
      end
   endtask

   // Monitor: every expected window must appear exactly one cycle after its read.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("rd_valid_k3", if3.rd_valid, q3.size() != 0);
         if (q3.size() != 0) chk("rd_taps_k3", {32'd0, if3.rd_taps}, q3.pop_front());
         chk("rd_valid_k5", if5.rd_valid, q5.size() != 0);
         if (q5.size() != 0) chk("rd_taps_k5", {16'd0, if5.rd_taps}, q5.pop_front());
      end
   end

   initial begin
      int pc, pi;
      bool_dummy: begin end
      rst_n = 1'b1;
      drive_idle();
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      if3.wr_en = 1'b1; if3.wr_last = 1'b1; if3.rd_en = 1'b1; if3.rd_done = 1'b1;
      if3.wr_data = 16'hBEEF;
      #1;
      chk_reset_outputs();
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // First frame into bank 0, with out-of-range writes mixed in.
      rd(2, 5);
      fill_frame(1, 1'b1, 1'b0);
      idle();
      rd(2, 0); rd(2, 10); rd(2, L - 1);
      rd(7, 5); rd(2, 210); rd(6, 10);
      idle();

      // Second frame fills bank 1: no free bank, blocked write, data unchanged.
      fill_frame(2, 1'b0, 1'b0);
      idle();
      step(1'b1, 2, 10, 16'h7777, 1'b1, 1'b0, 0, 0, 1'b0);
      rd(2, 10); rd(2, 9);
      // Release bank 0 with a read in the same cycle (still old bank).
      step(1'b0, 0, 0, 16'd0, 1'b0, 1'b1, 2, 11, 1'b1);
      rd(0, 1); rd(0, 0); rd(0, L - 2); rd(0, L - 1);
      idle();

      // Commit and release in the same cycle with one frame held.
      fill_frame(0, 1'b0, 1'b1);
      idle();
      rd(0, 0); rd(3, 77); rd(5, L - 1);
      idle();

      // Randomised producer/consumer traffic.
      pc = 0; pi = 0;
      for (int n = 0; n < 9000; n++) begin
         bit re, done, oor, pwe;
         re   = ($urandom % 2) == 0;
         done = ($urandom % 1500) == 0;
         oor  = ($urandom % 20) == 0;
         pwe  = ($urandom % 8) != 0;
         if (oor) begin
            step(1'b1, 6 + int'($urandom % 2), int'($urandom % L), 16'($urandom), 1'b0,
                 re, int'($urandom % 8), int'($urandom_range(0, L + 15)), done);
         end else begin
            step(pwe, pc, pi, 16'($urandom), (pc == C - 1) && (pi == L - 1),
                 re, int'($urandom % 8), int'($urandom_range(0, L + 15)), done);
            if (pwe && last_wr_ok) begin
               pi++;
               if (pi == L) begin pi = 0; pc = (pc == C - 1) ? 0 : pc + 1; end
            end
         end
      end
      repeat (3) idle();

      // Asynchronous reset in the middle of a frame.
      for (int i = 0; i < 50; i++) step(1'b1, 2, i, 16'(i), 1'b0, 1'b0, 0, 0, 1'b0);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      model_reset();
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      fill_frame(1, 1'b0, 1'b0);
      rd(2, L - 1); rd(2, 0); rd(4, 100);
      step(1'b0, 0, 0, 16'd0, 1'b0, 1'b0, 0, 0, 1'b1);
      repeat (3) idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
